// File: rtl/pay_barcode_serializer.sv
// rtl/pay_barcode_serializer.sv - frames {ClientB, ValueToPay} plus even parity into a bar/space barcode
// and shifts it out one module at a time on Bar.
module pay_barcode_serializer #(
    parameter int MODULE_CYCLES = 4,
    parameter int QUIET_MODULES = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [5:0] ValueToPay,
    input  logic       ClientB,
    output logic       Busy,
    output logic       Bar,
    output logic       Done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_START,
        S_DATA,
        S_STOP,
        S_TRAIL
    } state_t;

    localparam logic [7:0] CYC_LAST   = 8'(MODULE_CYCLES - 1);
    localparam logic [3:0] QUIET_LAST = 4'(QUIET_MODULES - 1);

    state_t     r_state;
    logic [7:0] r_cyc;
    logic [3:0] r_mod;
    logic [2:0] r_sym;
    logic [1:0] r_phase;
    logic [6:0] r_payload;
    logic       r_busy;
    logic       r_bar;
    logic       r_done;

    state_t     w_nstate;
    logic [3:0] w_nmod;
    logic [2:0] w_nsym;
    logic [1:0] w_nphase;
    logic       w_nbar;

    // Module value for a frame position; data symbols are 1,b,0 with b taken MSB first.
    function automatic logic bar_of(input state_t st, input logic [3:0] md, input logic [2:0] sy,
                                    input logic [1:0] ph, input logic [6:0] p);
        logic [7:0] syms;
        logic       b;
        syms = {p, ^p};
        b    = syms[3'd7 - sy];
        case (st)
            S_START: bar_of = ~md[0];
            S_DATA:  bar_of = (ph == 2'd0) | ((ph == 2'd1) & b);
            S_STOP:  bar_of = (md != 4'd1);
            default: bar_of = 1'b0;
        endcase
    endfunction

    // Frame position reached when the current module ends.
    always_comb begin
        w_nstate = r_state;
        w_nmod   = 4'(r_mod + 4'd1);
        w_nsym   = r_sym;
        w_nphase = r_phase;
        case (r_state)
            S_LEAD: begin
                if (r_mod == QUIET_LAST) begin
                    w_nstate = S_START;
                    w_nmod   = 4'd0;
                end
            end
            S_START: begin
                if (r_mod == 4'd3) begin
                    w_nstate = S_DATA;
                    w_nmod   = 4'd0;
                    w_nsym   = 3'd0;
                    w_nphase = 2'd0;
                end
            end
            S_DATA: begin
                w_nmod = r_mod;
                if (r_phase == 2'd2) begin
                    w_nphase = 2'd0;
                    if (r_sym == 3'd7) begin
                        w_nstate = S_STOP;
                        w_nmod   = 4'd0;
                    end else begin
                        w_nsym = 3'(r_sym + 3'd1);
                    end
                end else begin
                    w_nphase = 2'(r_phase + 2'd1);
                end
            end
            S_STOP: begin
                if (r_mod == 4'd3) begin
                    w_nstate = S_TRAIL;
                    w_nmod   = 4'd0;
                end
            end
            S_TRAIL: begin
                if (r_mod == QUIET_LAST) begin
                    w_nstate = S_IDLE;
                    w_nmod   = 4'd0;
                end
            end
            default: w_nmod = 4'd0;
        endcase
        w_nbar = bar_of(w_nstate, w_nmod, w_nsym, w_nphase, r_payload);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_cyc     <= 8'd0;
            r_mod     <= 4'd0;
            r_sym     <= 3'd0;
            r_phase   <= 2'd0;
            r_payload <= 7'd0;
            r_busy    <= 1'b0;
            r_bar     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (Start) begin
                    r_payload <= {ClientB, ValueToPay};
                    r_state   <= S_LEAD;
                    r_cyc     <= 8'd0;
                    r_mod     <= 4'd0;
                    r_sym     <= 3'd0;
                    r_phase   <= 2'd0;
                    r_busy    <= 1'b1;
                    r_bar     <= 1'b0;
                end
            end else if (r_cyc != CYC_LAST) begin
                r_cyc <= 8'(r_cyc + 8'd1);
            end else begin
                r_cyc   <= 8'd0;
                r_state <= w_nstate;
                r_mod   <= w_nmod;
                r_sym   <= w_nsym;
                r_phase <= w_nphase;
                r_bar   <= w_nbar;
                if (w_nstate == S_IDLE) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign Busy = r_busy;
    assign Bar  = r_bar;
    assign Done = r_done;

endmodule
